// File: rtl/snake_body_if.sv
// snake_body_if: control/status bundle between the game controller and snake_body.
//   master : game controller side, drives step/dir/dir_valid/grow, observes body and status.
//   slave  : snake_body side, consumes control pulses, publishes body and status.
//   snake_out packs segment i at [8i+7:8i] as {y[3:0], x[3:0]}; segment 0 is the head.
interface snake_body_if #(
    parameter int unsigned MAX_LEN = 225
);
    logic                     step;
    logic [1:0]               dir;
    logic                     dir_valid;
    logic                     grow;
    logic [8*MAX_LEN-1:0]     snake_out;
    logic [7:0]               length;
    logic [3:0]               head_x;
    logic [3:0]               head_y;
    logic                     busy;
    logic                     done;
    logic                     game_over;

    modport master (
        output step, dir, dir_valid, grow,
        input  snake_out, length, head_x, head_y, busy, done, game_over
    );

    modport slave (
        input  step, dir, dir_valid, grow,
        output snake_out, length, head_x, head_y, busy, done, game_over
    );
endinterface

// File: rtl/snake_body.sv
// snake_body: owns the snake segment list and advances it one cell per step.
//   clk, reset : clock and synchronous active-high reset.
//   bus        : snake_body_if slave port.
//     step/dir/dir_valid/grow        : move request, steering and growth inputs.
//     snake_out/length/head_x/head_y : registered body, updated on the commit edge.
//     busy/done/game_over            : move in progress, move committed pulse, sticky death.
// A move walks CALC (new head + wall test), CHECK (one body compare per cycle)
// and COMMIT (shift body, place head). Any wall or body hit parks the FSM in DEAD.
module snake_body #(
    parameter int unsigned MAX_LEN = 225
) (
    input  logic         clk,
    input  logic         reset,
    snake_body_if.slave  bus
);
    localparam int unsigned SEG_W = 8;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned IDX_W = $clog2(MAX_LEN);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_CHECK,
        S_COMMIT,
        S_DEAD
    } state_t;

    state_t                          state;
    logic [MAX_LEN-1:0][SEG_W-1:0]   seg;
    logic [MAX_LEN-1:0][SEG_W-1:0]   seg_shift_c;
    logic [1:0]                      cur_dir;
    logic [1:0]                      next_dir;
    logic                            pend_grow;
    logic                            grow_late;
    logic                            growing;
    logic [SEG_W-1:0]                new_head;
    logic [LEN_W-1:0]                len_q;
    logic [LEN_W-1:0]                k_q;
    logic [LEN_W-1:0]                idx_q;
    logic [3:0]                      head_x_q;
    logic [3:0]                      head_y_q;
    logic                            busy_q;
    logic                            done_q;
    logic                            over_q;

    logic [3:0]                      old_x_c;
    logic [3:0]                      old_y_c;
    logic [3:0]                      cand_x_c;
    logic [3:0]                      cand_y_c;
    logic                            wall_hit_c;
    logic                            grow_now_c;
    logic [1:0]                      steer_ref_c;
    logic                            dir_ok_c;
    logic [SEG_W-1:0]                seg_cmp_c;

    assign old_x_c = seg[0][3:0];
    assign old_y_c = seg[0][7:4];

    // Candidate head from the old head and the direction being committed; no wrap.
    always_comb begin
        wall_hit_c = 1'b0;
        cand_x_c   = old_x_c;
        cand_y_c   = old_y_c;
        case (next_dir)
            DIR_UP: begin
                if (old_y_c == 4'd0) wall_hit_c = 1'b1;
                else                 cand_y_c   = old_y_c - 4'd1;
            end
            DIR_RIGHT: begin
                if (old_x_c == 4'd15) wall_hit_c = 1'b1;
                else                  cand_x_c   = old_x_c + 4'd1;
            end
            DIR_DOWN: begin
                if (old_y_c == 4'd15) wall_hit_c = 1'b1;
                else                  cand_y_c   = old_y_c + 4'd1;
            end
            default: begin
                if (old_x_c == 4'd0) wall_hit_c = 1'b1;
                else                 cand_x_c   = old_x_c - 4'd1;
            end
        endcase
    end

    assign grow_now_c = pend_grow && (len_q < LEN_W'(MAX_LEN));

    // In CALC, cur_dir is about to take next_dir, so reversals are judged against that.
    assign steer_ref_c = (state == S_CALC) ? next_dir : cur_dir;
    assign dir_ok_c    = (bus.dir != (steer_ref_c ^ 2'b10));

    assign seg_cmp_c = seg[IDX_W'(idx_q)];

    // Body after the move: everything slides back one slot, the vacated tail is cleared.
    always_comb begin
        seg_shift_c = {seg[MAX_LEN-2:0], new_head};
        if (!growing && (len_q < LEN_W'(MAX_LEN))) begin
            seg_shift_c[IDX_W'(len_q)] = '0;
        end
    end

    // Move sequencer plus steering/growth capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            seg       <= '0;
            seg[0]    <= 8'h88;
            seg[1]    <= 8'h87;
            seg[2]    <= 8'h86;
            cur_dir   <= DIR_RIGHT;
            next_dir  <= DIR_RIGHT;
            pend_grow <= 1'b0;
            grow_late <= 1'b0;
            growing   <= 1'b0;
            new_head  <= '0;
            len_q     <= LEN_W'(3);
            k_q       <= '0;
            idx_q     <= '0;
            head_x_q  <= 4'd8;
            head_y_q  <= 4'd8;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (state != S_DEAD) begin
                if (bus.dir_valid && dir_ok_c) next_dir <= bus.dir;
                // Growth seen once a move is underway belongs to the following move.
                if (bus.grow) begin
                    if (state == S_IDLE) pend_grow <= 1'b1;
                    else                 grow_late <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.step) begin
                        state  <= S_CALC;
                        busy_q <= 1'b1;
                    end
                end
                S_CALC: begin
                    cur_dir <= next_dir;
                    if (wall_hit_c) begin
                        state  <= S_DEAD;
                        busy_q <= 1'b0;
                    end else begin
                        new_head <= {cand_y_c, cand_x_c};
                        growing  <= grow_now_c;
                        // Non-growing moves skip the tail: it vacates its cell this tick.
                        k_q      <= len_q - LEN_W'(1) + LEN_W'(grow_now_c);
                        idx_q    <= '0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (seg_cmp_c == new_head) begin
                        state  <= S_DEAD;
                        busy_q <= 1'b0;
                    end else if (idx_q == k_q - LEN_W'(1)) begin
                        state <= S_COMMIT;
                    end else begin
                        idx_q <= idx_q + LEN_W'(1);
                    end
                end
                S_COMMIT: begin
                    seg       <= seg_shift_c;
                    if (growing) len_q <= len_q + LEN_W'(1);
                    head_x_q  <= new_head[3:0];
                    head_y_q  <= new_head[7:4];
                    pend_grow <= grow_late | bus.grow;
                    grow_late <= 1'b0;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
                S_DEAD: begin
                    over_q <= 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.snake_out = seg;
    assign bus.length    = len_q;
    assign bus.head_x    = head_x_q;
    assign bus.head_y    = head_y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.game_over = over_q;
endmodule

// File: doc/snake_body.md
# snake_body

Game-state block that owns the snake's segment list and advances it one grid cell per game tick. Sits directly upstream of the snake grid writer. It publishes the full body as a packed coordinate vector plus the current length, so the writer can walk the segments and paint them into the grid memory. It also handles steering, growth after eating, and wall and self-collision detection, raising `game_over` when the snake dies.

## Interface
Parameters:
- `MAX_LEN`, 225: maximum number of segments (16×16 grid minus margin); sets the width of `snake_out`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high; clock `clk`.
- `step`, in, 1: one-cycle pulse requesting one movement; honoured only in IDLE.
- `dir`, in, 2: requested direction. 0 = up (y−1), 1 = right (x+1), 2 = down (y+1), 3 = left (x−1).
- `dir_valid`, in, 1: samples `dir` this cycle.
- `grow`, in, 1: one-cycle pulse, food eaten; the next committed move lengthens the snake by 1.
- `snake_out`, out, 8*MAX_LEN: packed segments; segment i at bits [8i+7:8i] = {y[3:0], x[3:0]}; segment 0 is the head; unused segments are 0.
- `length`, out, 8: number of valid segments.
- `head_x`, `head_y`, out, 4 each: copy of segment 0.
- `busy`, out, 1: high in any state other than IDLE and DEAD.
- `done`, out, 1: one-cycle pulse; the move has been committed and outputs are updated.
- `game_over`, out, 1: sticky; set on wall hit or self-collision.

## Operation
- Reset values:
  - segments 0..2 = (8,8), (7,8), (6,8); all other segments 0; `length` = 3.
  - `cur_dir` = `next_dir` = right.
  - `pend_grow` = 0; `busy` = `done` = `game_over` = 0; state IDLE.
- Steering:
  - When `dir_valid` is high, `next_dir` ← `dir`, unless `dir` is the exact reverse of `cur_dir`. A reverse request is dropped.
  - Accepted at any state except DEAD. The last valid write before CALC wins.
- Growth:
  - A `grow` pulse in any state except DEAD sets `pend_grow`.
  - `pend_grow` is consumed (cleared) in COMMIT.
  - If `length` == MAX_LEN, `pend_grow` is cleared without growing.
- FSM states: IDLE, CALC, CHECK, COMMIT, DEAD.
  - IDLE: on `step` → CALC. A `step` pulse in any other state is ignored; it is not queued.
  - CALC:
    - `cur_dir` ← `next_dir`.
    - Compute the new head from the old head and `next_dir`, with no wrap-around.
    - If x or y would leave 0..15 (x=15 moving right, x=0 moving left, same for y) → DEAD. Segments stay unchanged.
    - Otherwise latch `K` = length−1 + g, where g = 1 if `pend_grow` and length < MAX_LEN, else 0. Set `idx` ← 0 and go to CHECK.
    - K excludes the tail on a non-growing move, because the tail vacates its cell this tick.
  - CHECK: one segment compared per cycle.
    - If segment[idx] == new head → DEAD.
    - Else if idx == K−1 → COMMIT.
    - Else idx+1.
  - COMMIT: in a single cycle:
    - segment[i] ← segment[i−1] for i = 1..MAX_LEN−1; segment[0] ← new head.
    - If growing, `length` += 1. Otherwise segment[length] ← 0, which clears the vacated tail slot.
    - Pulse `done`, then → IDLE.
  - DEAD: `game_over` = 1. All outputs are frozen. `step`, `grow` and `dir_valid` are ignored. Exit only via `reset`.
- `reset` overrides every state, including mid-CHECK, and restores reset values on the next edge.

## Timing
- Outputs are registered. `snake_out`, `length`, `head_*` and `done` all change on the same edge (the COMMIT edge).
- Let the step edge be the edge where `step` is sampled in IDLE. `done` is high during the cycle following edge K+2 after the step edge.
  - Example: length 3, no grow → K = 2, `done` appears after 4 edges.
- Wall death: `game_over` is high after 2 edges. Self-collision at idx j: `game_over` is high after j+3 edges.
- `busy` rises the cycle after the step edge and falls in the same cycle that `done` rises.
- `grow` or `dir_valid` arriving during CHECK or COMMIT affects the next move only.

## Test plan
- Reset, then 4 `step` pulses spaced 10 cycles apart with no `dir` → head (12,8), tail (10,8), length 3, segment 3 = 0. Each `done` appears 4 edges after its step.
- `grow` pulse, then `step` → length 4, segments (9,8), (8,8), (7,8), (6,8). `done` appears 5 edges after step; `pend_grow` is cleared.
- `dir`=3 (reverse) with `dir_valid`, then `step` → request ignored, head moves to (9,8). Then `dir`=0, `step` → head (9,7).
- 7 steps right from reset → head (15,8). 8th step → `game_over` at edge 2, `snake_out` unchanged, later `step`s ignored.
- Grow to length 5, then steer down, left, up → new head equals segment 3, `game_over` asserts, `done` never pulses. `reset` → initial 3-segment snake.
- `step` pulsed again during CHECK → ignored, exactly one `done`. `reset` asserted mid-CHECK → reset values on the next edge, `busy` = 0.
